match_ctrl: RTL and testbench

Match-level controller for pong, sitting directly downstream of the game logic's out-of-bounds flags and upstream of the scoreboard and ball serve. It owns the match state machine (idle, serve countdown, rally, point award, game over) and keeps both players' scores. It issues a timed serve pulse with a randomised start row and serving direction, and declares the winner. It runs on the game clock.

---
 rtl/pong_pkg.sv | 24 ++
 rtl/rise_detect.sv | 26 ++
 rtl/match_ctrl.sv | 171 +++++++++++++++++
 tb/tb_match_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong match types, widths and winner encodings
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam int ROW_W   = 5;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_WAIT,
        PLAY,
        POINT,
        OVER
    } match_state_t;

    // Scores saturate at 15 rather than wrapping back to zero.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == '1) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - one-register rising-edge detector
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - pong match FSM and scores; PONG_WIN_BY_TWO_EN selects win-by-two
module match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 1500
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               out_left,
    input  logic               out_right,
    input  logic [ROW_W-1:0]   entropy,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               serve,
    output logic [ROW_W-1:0]   serve_y,
    output logic               serve_dir,
    output logic               play,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam int                 CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CNT_W-1:0]   LOAD  = CNT_W'(SERVE_DELAY - 1);
    localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);

    logic start_rise;
    logic left_rise;
    logic right_rise;

    rise_detect u_rd_start (.clk(clk), .reset(reset), .d(start),     .rise(start_rise));
    rise_detect u_rd_left  (.clk(clk), .reset(reset), .d(out_left),  .rise(left_rise));
    rise_detect u_rd_right (.clk(clk), .reset(reset), .d(out_right), .rise(right_rise));

    match_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic               serve_q, serve_d;
    logic [ROW_W-1:0]   serve_y_q, serve_y_d;
    logic               dir_q, dir_d;
    logic               play_q, play_d;
    logic               over_q, over_d;
    logic [1:0]         winner_q, winner_d;

    logic [SCORE_W-1:0] p1_new, p2_new, new_s, opp_s;
    logic               scorer_p1;
    logic               win;

    // The serve direction was just pointed at the loser, so it also names the scorer.
    always_comb begin
        p1_new    = sat_inc(p1_q);
        p2_new    = sat_inc(p2_q);
        scorer_p1 = dir_q;
        new_s     = scorer_p1 ? p1_new : p2_new;
        opp_s     = scorer_p1 ? p2_q : p1_q;
`ifdef PONG_WIN_BY_TWO_EN
        win = (new_s == '1) ||
              ((new_s >= WIN_S) && ({1'b0, new_s} >= ({1'b0, opp_s} + 5'd2)));
`else
        win = (new_s == WIN_S);
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        serve_d   = 1'b0;
        serve_y_d = serve_y_q;
        dir_d     = dir_q;
        winner_d  = winner_q;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    p1_d    = '0;
                    p2_d    = '0;
                    cnt_d   = LOAD;
                    state_d = SERVE_WAIT;
                end
            end
            SERVE_WAIT: begin
                if (cnt_q == '0) begin
                    serve_d   = 1'b1;
                    serve_y_d = entropy;
                    state_d   = PLAY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PLAY: begin
                if (left_rise && right_rise) begin
                    cnt_d   = LOAD;
                    state_d = SERVE_WAIT;
                end else if (left_rise) begin
                    dir_d   = 1'b0;
                    state_d = POINT;
                end else if (right_rise) begin
                    dir_d   = 1'b1;
                    state_d = POINT;
                end
            end
            POINT: begin
                if (scorer_p1) begin
                    p1_d = p1_new;
                end else begin
                    p2_d = p2_new;
                end
                if (win) begin
                    winner_d = scorer_p1 ? WIN_P1 : WIN_P2;
                    state_d  = OVER;
                end else begin
                    cnt_d   = LOAD;
                    state_d = SERVE_WAIT;
                end
            end
            OVER: begin
                if (start_rise) begin
                    p1_d     = '0;
                    p2_d     = '0;
                    winner_d = WIN_NONE;
                    dir_d    = 1'b1;
                    cnt_d    = LOAD;
                    state_d  = SERVE_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        play_d = (state_d == PLAY);
        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            serve_q   <= 1'b0;
            serve_y_q <= '0;
            dir_q     <= 1'b1;
            play_q    <= 1'b0;
            over_q    <= 1'b0;
            winner_q  <= WIN_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            serve_q   <= serve_d;
            serve_y_q <= serve_y_d;
            dir_q     <= dir_d;
            play_q    <= play_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
        end
    end

    assign score_p1  = p1_q;
    assign score_p2  = p2_q;
    assign serve     = serve_q;
    assign serve_y   = serve_y_q;
    assign serve_dir = dir_q;
    assign play      = play_q;
    assign game_over = over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// tb/tb_match_ctrl.sv - randomized directed bench for match_ctrl against a point-level score model
module tb_match_ctrl;

    localparam int W = 3;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       out_left = 1'b0;
    logic       out_right = 1'b0;
    logic [4:0] entropy = 5'd0;
    logic [3:0] score_p1, score_p2;
    logic       serve, serve_dir, play, game_over;
    logic [4:0] serve_y;
    logic [1:0] winner;

    match_ctrl #(.WIN_SCORE(W), .SERVE_DELAY(D)) dut (
        .clk(clk), .reset(reset), .start(start), .out_left(out_left),
        .out_right(out_right), .entropy(entropy), .score_p1(score_p1),
        .score_p2(score_p2), .serve(serve), .serve_y(serve_y),
        .serve_dir(serve_dir), .play(play), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int       m_p1 = 0;
    int       m_p2 = 0;
    logic     m_dir = 1'b1;
    logic [1:0] m_win = 2'b00;
    logic     m_over = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_wins(input int mine, input int opp);
`ifdef PONG_WIN_BY_TWO_EN
        return (mine == 15) || ((mine >= W) && (mine - opp >= 2));
`else
        return mine == W;
`endif
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, "_p1"}, 32'(score_p1), 32'(m_p1));
        chk({tag, "_p2"}, 32'(score_p2), 32'(m_p2));
        chk({tag, "_winner"}, 32'(winner), 32'(m_win));
        chk({tag, "_over"}, 32'(game_over), 32'(m_over));
    endtask

    // Called after the edge that entered the serve countdown: serve lands D edges later.
    task automatic serve_wait(input string tag);
        logic [4:0] e;
        for (int i = 1; i <= D; i++) begin
            e = 5'($urandom);
            entropy = e;
            tick();
            if (i < D) begin
                chk({tag, "_early_serve"}, 32'(serve), 32'd0);
                chk({tag, "_early_play"}, 32'(play), 32'd0);
            end else begin
                chk({tag, "_serve"}, 32'(serve), 32'd1);
                chk({tag, "_serve_y"}, 32'(serve_y), 32'(e));
                chk({tag, "_play"}, 32'(play), 32'd1);
                chk({tag, "_dir"}, 32'(serve_dir), 32'(m_dir));
            end
        end
        tick();
        chk({tag, "_serve_pulse"}, 32'(serve), 32'd0);
        chk({tag, "_still_play"}, 32'(play), 32'd1);
    endtask

    // side: 0 out_left (P2 scores), 1 out_right (P1 scores), 2 both at once
    task automatic point(input int side, input bit hold);
        out_left  = (side != 1);
        out_right = (side != 0);
        tick();
        chk("pt_play_drop", 32'(play), 32'd0);
        chk_state("pt_before");
        if (!hold) begin
            out_left  = 1'b0;
            out_right = 1'b0;
        end
        if (side == 2) begin
            serve_wait("both");
        end else begin
            if (side == 0) begin
                m_p2  = (m_p2 < 15) ? m_p2 + 1 : 15;
                m_dir = 1'b0;
                if (model_wins(m_p2, m_p1)) begin m_over = 1'b1; m_win = 2'b10; end
            end else begin
                m_p1  = (m_p1 < 15) ? m_p1 + 1 : 15;
                m_dir = 1'b1;
                if (model_wins(m_p1, m_p2)) begin m_over = 1'b1; m_win = 2'b01; end
            end
            tick();
            chk_state("pt_after");
            chk("pt_dir", 32'(serve_dir), 32'(m_dir));
            chk("pt_play", 32'(play), 32'd0);
            if (!m_over) serve_wait("pt");
        end
    endtask

    task automatic restart(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_p1 = 0; m_p2 = 0; m_dir = 1'b1; m_win = 2'b00; m_over = 1'b0;
        chk_state(tag);
        serve_wait(tag);
    endtask

    initial begin
        // reset
        tick();
        tick();
        chk_state("rst");
        chk("rst_serve", 32'(serve), 32'd0);
        chk("rst_serve_y", 32'(serve_y), 32'd0);
        chk("rst_play", 32'(play), 32'd0);
        chk("rst_dir", 32'(serve_dir), 32'd1);
        reset = 1'b1;

        // idle until edge 9, start rise lands on edge 10
        for (int e = 3; e <= 9; e++) begin
            tick();
            chk("idle_serve", 32'(serve), 32'd0);
            chk("idle_play", 32'(play), 32'd0);
        end
        restart("start");

        point(1, 1'b0);
        point(2, 1'b0);
        point(0, 1'b0);
        point(0, 1'b0);
        point(0, 1'b0);
        chk("p2_win_over", 32'(game_over), 32'd1);

        // edges in OVER are ignored
        for (int i = 0; i < 6; i++) begin
            out_left  = 1'($urandom);
            out_right = 1'($urandom);
            tick();
            chk_state("over_hold");
            chk("over_play", 32'(play), 32'd0);
            chk("over_serve", 32'(serve), 32'd0);
        end
        out_left = 1'b0;
        out_right = 1'b0;
        tick();
        restart("restart1");

        // out_left held high into the next rally, start pulses during PLAY
        point(0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            start = (i % 2 == 0);
            tick();
            chk("hold_play", 32'(play), 32'd1);
            chk("hold_serve", 32'(serve), 32'd0);
            chk_state("hold");
        end
        start = 1'b0;
        out_left = 1'b0;
        tick();

        // random rally to a finish
        for (int n = 0; n < 60 && !m_over; n++) begin
            int r;
            r = $urandom_range(0, 9);
            point((r < 4) ? 0 : ((r < 8) ? 1 : 2), 1'b0);
        end
        chk("rand_over", 32'(game_over), 32'd1);
        restart("restart2");

`ifdef PONG_WIN_BY_TWO_EN
        for (int i = 0; i < 3; i++) begin
            point(1, 1'b0);
            point(0, 1'b0);
        end
        point(1, 1'b0);
        chk("w2_4_3_winner", 32'(winner), 32'd0);
        point(1, 1'b0);
        chk("w2_5_3_winner", 32'(winner), 32'd1);
        restart("restart3");
`endif

        // reset during SERVE_WAIT
        out_right = 1'b1;
        tick();
        out_right = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        m_p1 = 0; m_p2 = 0; m_dir = 1'b1; m_win = 2'b00; m_over = 1'b0;
        chk_state("mid_rst");
        chk("mid_rst_serve", 32'(serve), 32'd0);
        chk("mid_rst_play", 32'(play), 32'd0);
        chk("mid_rst_dir", 32'(serve_dir), 32'd1);
        reset = 1'b1;
        for (int i = 0; i < D + 3; i++) begin
            tick();
            chk("post_rst_serve", 32'(serve), 32'd0);
            chk("post_rst_play", 32'(play), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
